// File: rtl/dac_pkg.sv
// Shared types and defaults for the DAC playback scheduler.
package dac_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DIV_W_DEF  = 16;
    localparam int PASS_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READY  = 2'd1,
        ST_PLAY   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/dac_play_sched_if.sv
// Signal bundle for the playback scheduler's config, command and read side.
interface dac_play_sched_if
    import dac_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_start_addr;
    logic [ADDR_W-1:0] cfg_length;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_loop;
    logic              cmd_start;
    logic              cmd_stop;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic [PASS_W-1:0] pass_cnt;

    modport master (
        output cfg_valid, cfg_start_addr, cfg_length, cfg_div, cfg_loop,
        output cmd_start, cmd_stop,
        input  cfg_ready, rd_en, rd_addr, busy, done, cfg_err, pass_cnt
    );

    modport slave (
        input  cfg_valid, cfg_start_addr, cfg_length, cfg_div, cfg_loop,
        input  cmd_start, cmd_stop,
        output cfg_ready, rd_en, rd_addr, busy, done, cfg_err, pass_cnt
    );
endinterface

// File: rtl/dac_rate_div.sv
// Sample-period divider: one tick every div_i+1 enabled clocks.
module dac_rate_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = div_i;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? div_i : cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/dac_play_sched.sv
// Buffer playback scheduler: config latch, play FSM, address and pass counters.
module dac_play_sched
    import dac_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_start_addr,
    input  logic [ADDR_W-1:0] cfg_length,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_loop,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [PASS_W-1:0] pass_cnt
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              loop_q, loop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic              rd_en_q, rd_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rdy_q, rdy_d;
    logic              hs, last, go, tick;

    assign hs   = cfg_valid && rdy_q;
    assign last = (idx_q == len_q - ADDR_W'(1));

    dac_rate_div #(.DIV_W(DIV_W)) u_div (
        .clk_i  (axi_aclk),
        .rst_i  (axi_areset),
        .load_i (go),
        .en_i   (state_q == ST_PLAY),
        .div_i  (div_q),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        len_d   = len_q;
        div_d   = div_q;
        loop_d  = loop_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        rd_en_d = 1'b0;
        err_d   = 1'b0;
        go      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_READY: begin
                if (hs) begin
                    if (cfg_length != '0) begin
                        start_d = cfg_start_addr;
                        len_d   = cfg_length;
                        div_d   = cfg_div;
                        loop_d  = cfg_loop;
                        state_d = ST_READY;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (state_q == ST_READY && cmd_start) begin
                    go      = 1'b1;
                    state_d = ST_PLAY;
                    rd_en_d = 1'b1;
                    addr_d  = start_q;
                    idx_d   = '0;
                    pass_d  = '0;
                end
            end
            ST_PLAY: begin
                // A pass is counted the cycle after its final sample.
                if (rd_en_q && last && pass_q != '1) begin
                    pass_d = pass_q + PASS_W'(1);
                end
                if (cmd_stop) begin
                    state_d = ST_FINISH;
                end else if (rd_en_q && last && !loop_q) begin
                    state_d = ST_FINISH;
                end else if (tick) begin
                    rd_en_d = 1'b1;
                    addr_d  = last ? start_q : addr_q + ADDR_W'(1);
                    idx_d   = last ? '0 : idx_q + ADDR_W'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_READY;
            end
        endcase
        busy_d = (state_d == ST_PLAY);
        done_d = (state_q == ST_PLAY) && (state_d == ST_FINISH);
        rdy_d  = (state_d == ST_IDLE) || (state_d == ST_READY);
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q <= ST_IDLE;
            start_q <= '0;
            len_q   <= '0;
            div_q   <= '0;
            loop_q  <= 1'b0;
            addr_q  <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            len_q   <= len_d;
            div_q   <= div_d;
            loop_q  <= loop_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    assign cfg_ready = rdy_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = err_q;
    assign pass_cnt  = pass_q;
endmodule

// File: tb/tb_dac_play_sched.sv
// Directed self-checking bench for dac_play_sched.
module tb_dac_play_sched;
    import dac_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dac_play_sched_if #(.ADDR_W(16), .DIV_W(16)) dif ();

    dac_play_sched #(.ADDR_W(16), .DIV_W(16)) dut (
        .axi_aclk       (clk),
        .axi_areset     (rst),
        .cfg_valid      (dif.cfg_valid),
        .cfg_ready      (dif.cfg_ready),
        .cfg_start_addr (dif.cfg_start_addr),
        .cfg_length     (dif.cfg_length),
        .cfg_div        (dif.cfg_div),
        .cfg_loop       (dif.cfg_loop),
        .cmd_start      (dif.cmd_start),
        .cmd_stop       (dif.cmd_stop),
        .rd_en          (dif.rd_en),
        .rd_addr        (dif.rd_addr),
        .busy           (dif.busy),
        .done           (dif.done),
        .cfg_err        (dif.cfg_err),
        .pass_cnt       (dif.pass_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] sa, input logic [15:0] ln,
                         input logic [15:0] dv, input logic lp);
        dif.cfg_valid      = 1'b1;
        dif.cfg_start_addr = sa;
        dif.cfg_length     = ln;
        dif.cfg_div        = dv;
        dif.cfg_loop       = lp;
        step();
        dif.cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({dif.rd_en, dif.rd_addr, dif.busy, dif.done, dif.cfg_err,
             dif.pass_cnt, dif.cfg_ready} !== 36'h0) begin
            $display("FAIL reset_hold: en=%b addr=%h busy=%b done=%b err=%b pass=%h rdy=%b, required all 0",
                     dif.rd_en, dif.rd_addr, dif.busy, dif.done, dif.cfg_err,
                     dif.pass_cnt, dif.cfg_ready);
            errors++;
        end
        rst = 1'b0;
        step();
        checks++;
        if (dif.cfg_ready !== 1'b1 || dif.busy !== 1'b0) begin
            $display("FAIL reset_release: rdy=%b busy=%b, required rdy=1 busy=0",
                     dif.cfg_ready, dif.busy);
            errors++;
        end
    endtask

    task automatic test_idle_start();
        dif.cmd_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (dif.rd_en !== 1'b0 || dif.busy !== 1'b0 || dif.cfg_ready !== 1'b1) begin
                $display("FAIL idle_start cyc %0d: en=%b busy=%b rdy=%b, required 0 0 1",
                         i, dif.rd_en, dif.busy, dif.cfg_ready);
                errors++;
            end
        end
        dif.cmd_start = 1'b0;
    endtask

    task automatic test_single_pass();
        logic        exp_en;
        logic [15:0] exp_addr;
        offer(16'h0010, 16'd4, 16'd2, 1'b0);
        checks++;
        if (dif.cfg_ready !== 1'b1 || dif.busy !== 1'b0) begin
            $display("FAIL single_cfg: rdy=%b busy=%b, required 1 0", dif.cfg_ready, dif.busy);
            errors++;
        end
        dif.cmd_start = 1'b1;
        step();
        dif.cmd_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp_en   = (i % 3 == 0) && (i <= 9);
            exp_addr = 16'(16'h0010 + i / 3);
            checks++;
            if (dif.rd_en !== exp_en || (exp_en && dif.rd_addr !== exp_addr)) begin
                $display("FAIL single_rd cyc %0d: en=%b addr=%h, required en=%b addr=%h",
                         i, dif.rd_en, dif.rd_addr, exp_en, exp_addr);
                errors++;
            end
            checks++;
            if (dif.done !== (i == 10) || dif.busy !== (i <= 9)) begin
                $display("FAIL single_stat cyc %0d: done=%b busy=%b, required done=%b busy=%b",
                         i, dif.done, dif.busy, (i == 10), (i <= 9));
                errors++;
            end
            step();
        end
        checks++;
        if (dif.pass_cnt !== 16'd1 || dif.cfg_ready !== 1'b1) begin
            $display("FAIL single_end: pass=%0d rdy=%b, required pass=1 rdy=1",
                     dif.pass_cnt, dif.cfg_ready);
            errors++;
        end
    endtask

    task automatic test_wrap();
        logic        exp_en;
        logic [15:0] exp_addr;
        dif.cmd_start = 1'b1;
        offer(16'hFFFE, 16'd4, 16'd0, 1'b0);
        checks++;
        if (dif.rd_en !== 1'b0 || dif.busy !== 1'b0) begin
            $display("FAIL cfg_priority: en=%b busy=%b, required 0 0", dif.rd_en, dif.busy);
            errors++;
        end
        step();
        dif.cmd_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_en   = (i <= 3);
            exp_addr = 16'(32'hFFFE + i);
            checks++;
            if (dif.rd_en !== exp_en || (exp_en && dif.rd_addr !== exp_addr)) begin
                $display("FAIL wrap_rd cyc %0d: en=%b addr=%h, required en=%b addr=%h",
                         i, dif.rd_en, dif.rd_addr, exp_en, exp_addr);
                errors++;
            end
            checks++;
            if (dif.done !== (i == 4)) begin
                $display("FAIL wrap_done cyc %0d: done=%b, required %b", i, dif.done, (i == 4));
                errors++;
            end
            step();
        end
    endtask

    task automatic test_loop_stop();
        logic        exp_en;
        logic [15:0] exp_addr;
        int          ndone = 0;
        offer(16'h0100, 16'd2, 16'd1, 1'b1);
        dif.cmd_start = 1'b1;
        step();
        dif.cmd_start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            exp_en   = (i % 2 == 0) && (i <= 8);
            exp_addr = ((i / 2) % 2 == 0) ? 16'h0100 : 16'h0101;
            checks++;
            if (dif.rd_en !== exp_en || (exp_en && dif.rd_addr !== exp_addr)) begin
                $display("FAIL loop_rd cyc %0d: en=%b addr=%h, required en=%b addr=%h",
                         i, dif.rd_en, dif.rd_addr, exp_en, exp_addr);
                errors++;
            end
            if (dif.done === 1'b1) ndone++;
            dif.cmd_stop = (i == 9);
            step();
        end
        dif.cmd_stop = 1'b0;
        checks++;
        if (ndone != 1 || dif.pass_cnt !== 16'd2 || dif.cfg_ready !== 1'b1) begin
            $display("FAIL loop_end: done_count=%0d pass=%0d rdy=%b, required 1 2 1",
                     ndone, dif.pass_cnt, dif.cfg_ready);
            errors++;
        end
    endtask

    task automatic test_illegal_cfg();
        offer(16'h5555, 16'd0, 16'd7, 1'b0);
        checks++;
        if (dif.cfg_err !== 1'b1 || dif.cfg_ready !== 1'b1 || dif.busy !== 1'b0) begin
            $display("FAIL illegal_err: err=%b rdy=%b busy=%b, required 1 1 0",
                     dif.cfg_err, dif.cfg_ready, dif.busy);
            errors++;
        end
        step();
        checks++;
        if (dif.cfg_err !== 1'b0) begin
            $display("FAIL illegal_pulse: err=%b, required 0", dif.cfg_err);
            errors++;
        end
        dif.cmd_start = 1'b1;
        step();
        dif.cmd_start = 1'b0;
        checks++;
        if (dif.rd_en !== 1'b1 || dif.rd_addr !== 16'h0100 || dif.pass_cnt !== 16'd0) begin
            $display("FAIL illegal_old0: en=%b addr=%h pass=%0d, required 1 0100 0",
                     dif.rd_en, dif.rd_addr, dif.pass_cnt);
            errors++;
        end
        step();
        step();
        checks++;
        if (dif.rd_en !== 1'b1 || dif.rd_addr !== 16'h0101) begin
            $display("FAIL illegal_old1: en=%b addr=%h, required 1 0101", dif.rd_en, dif.rd_addr);
            errors++;
        end
        dif.cmd_stop = 1'b1;
        step();
        dif.cmd_stop = 1'b0;
        checks++;
        if (dif.done !== 1'b1 || dif.rd_en !== 1'b0) begin
            $display("FAIL illegal_stop: done=%b en=%b, required 1 0", dif.done, dif.rd_en);
            errors++;
        end
        step();
    endtask

    task automatic test_reset_mid_play();
        offer(16'h0200, 16'd8, 16'd0, 1'b0);
        dif.cmd_start = 1'b1;
        step();
        dif.cmd_start = 1'b0;
        step();
        step();
        checks++;
        if (dif.rd_en !== 1'b1 || dif.rd_addr !== 16'h0202) begin
            $display("FAIL midplay_run: en=%b addr=%h, required 1 0202", dif.rd_en, dif.rd_addr);
            errors++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (dif.rd_en !== 1'b0 || dif.done !== 1'b0 || dif.busy !== 1'b0 ||
            dif.cfg_ready !== 1'b0 || dif.pass_cnt !== 16'd0) begin
            $display("FAIL midplay_rst: en=%b done=%b busy=%b rdy=%b pass=%0d, required all 0",
                     dif.rd_en, dif.done, dif.busy, dif.cfg_ready, dif.pass_cnt);
            errors++;
        end
        step();
        checks++;
        if (dif.cfg_ready !== 1'b1 || dif.done !== 1'b0) begin
            $display("FAIL midplay_rel: rdy=%b done=%b, required 1 0", dif.cfg_ready, dif.done);
            errors++;
        end
        dif.cmd_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (dif.rd_en !== 1'b0 || dif.busy !== 1'b0 || dif.done !== 1'b0) begin
                $display("FAIL midplay_idle cyc %0d: en=%b busy=%b done=%b, required 0 0 0",
                         i, dif.rd_en, dif.busy, dif.done);
                errors++;
            end
        end
        dif.cmd_start = 1'b0;
    endtask

    initial begin
        dif.cfg_valid      = 1'b0;
        dif.cfg_start_addr = '0;
        dif.cfg_length     = '0;
        dif.cfg_div        = '0;
        dif.cfg_loop       = 1'b0;
        dif.cmd_start      = 1'b0;
        dif.cmd_stop       = 1'b0;
        test_reset();
        test_idle_start();
        test_single_pass();
        test_wrap();
        test_loop_stop();
        test_illegal_cfg();
        test_reset_mid_play();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dac_play_sched.md
DAC_PLAY_SCHED -- requirements
Module: dac_play_sched

Interface
REQ-001 SHALL use parameter ADDR_W, default 16, meaning buffer read-address width.
REQ-002 SHALL use parameter DIV_W, default 16, meaning sample-period divider width.
REQ-003 SHALL have the following ports:
- axi_aclk  in  1  sole clock.
- axi_areset  in  1  reset; synchronous, active-high.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration accept.
- cfg_start_addr  in  ADDR_W  first sample address.
- cfg_length  in  ADDR_W  samples per pass; 0 is illegal.
- cfg_div  in  DIV_W  sample period = cfg_div+1 clocks.
- cfg_loop  in  1  1 = repeat passes until stopped.
- cmd_start  in  1  start playback (level sampled per cycle).
- cmd_stop  in  1  abort playback.
- rd_en  out  1  buffer read strobe, one clock per sample.
- rd_addr  out  ADDR_W  buffer read address, valid when rd_en=1.
- busy  out  1  state is PLAY.
- done  out  1  one-cycle pulse at end of playback.
- cfg_err  out  1  one-cycle pulse when cfg_length=0 is offered.
- pass_cnt  out  16  completed passes in current run.

Function
REQ-004 SHALL implement states IDLE (no valid config), READY (config held), PLAY and FINISH.
REQ-005 SHALL drive cfg_ready=1 in IDLE and READY, and 0 in PLAY and FINISH.
REQ-006 SHALL latch the configuration on cfg_valid&&cfg_ready with cfg_length!=0, then go to READY the next cycle.
REQ-007 SHALL, on cfg_valid&&cfg_ready with cfg_length=0, pulse cfg_err for one cycle, keep the state and keep any previously latched config.
REQ-008 SHALL ignore cmd_start in IDLE, FINISH and PLAY.
REQ-009 SHALL, on cmd_start in READY at cycle t, enter PLAY at t+1, assert rd_en at t+1 with rd_addr=start_addr, and clear pass_cnt to 0.
REQ-010 SHALL give cfg_valid priority over cmd_start when both are asserted in READY, with the start ignored that cycle.
REQ-011 SHALL, in PLAY, assert rd_en exactly once per div+1 clocks, so that div=0 gives rd_en every clock.
REQ-012 SHALL increment rd_addr by 1 per sample, modulo 2^ADDR_W, so that FFFF wraps to 0000 with no error.
REQ-013 SHALL, after sample length-1 of a pass with loop=1, issue the next sample at start_addr div+1 clocks later (seamless cadence) and increment pass_cnt, saturating at FFFF.
REQ-014 SHALL, after sample length-1 of a pass with loop=0, enter FINISH the next cycle, increment pass_cnt and issue no further rd_en.
REQ-015 SHALL, on cmd_stop in PLAY, enter FINISH the next cycle, with no rd_en in that cycle or afterwards; cmd_stop takes priority over a sample due in the same cycle.
REQ-016 SHALL ignore cmd_stop outside PLAY.
REQ-017 SHALL, in FINISH, pulse done for exactly one cycle, then go to READY with config retained and pass_cnt held until the next start.
REQ-018 SHALL register all outputs, with no combinational path from any input to rd_en or rd_addr.
REQ-019 SHALL have a total latency from cmd_start (cycle t) to done of t+1+(length-1)(div+1)+1 for loop=0 with no stop.

Reset
REQ-020 SHALL, on axi_areset=1 at a clock edge, go to IDLE and clear the latched config.
REQ-021 SHALL hold outputs at rd_en=0, rd_addr=0, busy=0, done=0, cfg_err=0, pass_cnt=0 and cfg_ready=0 while axi_areset=1, with cfg_ready=1 from the first cycle after reset is released.
REQ-022 SHALL, on reset mid-PLAY, drop rd_en in the cycle after the reset edge, and SHALL NOT emit done.

Structure
REQ-023 SHALL place the state encodings (IDLE=0, READY=1, PLAY=2, FINISH=3), ADDR_W and DIV_W defaults in the shared package dac_pkg.
REQ-024 SHALL implement the sample-rate divider as sub-module dac_rate_div (load, enable, tick out), with the FSM, address counter and pass counter in dac_play_sched.

Verification
REQ-025 SHALL cover single pass: cfg start=0x0010, length=4, div=2, loop=0, then cmd_start -> rd_en every 3 clocks at addr 0x10..0x13, done 1 clock after the 4th sample, pass_cnt=1.
REQ-026 SHALL cover wrap: start=0xFFFE, length=4, div=0 -> rd_addr FFFE, FFFF, 0000, 0001 on 4 consecutive clocks, then done.
REQ-027 SHALL cover loop plus stop: start=0x0100, length=2, div=1, loop=1, with cmd_stop after 5 samples -> addr sequence 100, 101, 100, 101, 100, then no rd_en, done once, pass_cnt=2.
REQ-028 SHALL cover an illegal config: cfg_length=0 offered in READY -> cfg_err 1-cycle pulse, state READY, and a later cmd_start plays the old config.
REQ-029 SHALL cover cmd_start in IDLE: no rd_en, busy=0, cfg_ready=1.
REQ-030 SHALL cover reset mid-PLAY: axi_areset for 1 clock during a run -> rd_en=0 next cycle, no done, state IDLE, and cmd_start then ignored until a new config.
